// File: rtl/clk_div_bank.sv
// Bank of independent runtime-programmable clock dividers sharing one input clock.
// Each channel emits a 50%-duty divided clock plus a tick strobe on every half-period.
module clk_div_bank #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 25,
    parameter int DEFAULT_DIV = 25000000,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_restart,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_ready,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    logic [CNT_W-1:0]  cnt    [NUM_CH];
    logic [CNT_W-1:0]  div    [NUM_CH];
    logic [CNT_W-1:0]  shadow [NUM_CH];
    logic [NUM_CH-1:0] cfg_hit;
    logic              ch_valid;
    logic              xfer;

    assign ch_valid = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));
    assign xfer     = cfg_valid & cfg_ready;

    // Out-of-range channels are always ready so a bad request is consumed and flagged.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pending[i];
            end
        end
    end

    always_comb begin
        cfg_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_hit[i] = xfer & (cfg_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
            clk_out <= '0;
            tick    <= '0;
            pending <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]    <= '0;
                div[i]    <= CNT_W'(DEFAULT_DIV);
                shadow[i] <= '0;
            end
        end else begin
            cfg_err <= xfer & ~ch_valid;
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync_restart) begin
                    // A write landing with the restart bypasses the shadow entirely.
                    cnt[i]     <= '0;
                    clk_out[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                    pending[i] <= 1'b0;
                    if (cfg_hit[i]) begin
                        div[i] <= cfg_div;
                    end else if (pending[i]) begin
                        div[i] <= shadow[i];
                    end
                end else if (!en[i] || div[i] == '0) begin
                    cnt[i]     <= '0;
                    clk_out[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                    if (pending[i]) begin
                        div[i]     <= shadow[i];
                        pending[i] <= 1'b0;
                    end else if (cfg_hit[i]) begin
                        shadow[i]  <= cfg_div;
                        pending[i] <= 1'b1;
                    end
                end else begin
                    // Divisor swaps only at terminal count, so every half-period is whole.
                    if (cnt[i] == div[i] - CNT_W'(1)) begin
                        cnt[i]     <= '0;
                        clk_out[i] <= ~clk_out[i];
                        tick[i]    <= 1'b1;
                        if (pending[i]) begin
                            div[i]     <= shadow[i];
                            pending[i] <= 1'b0;
                        end
                    end else begin
                        cnt[i]  <= cnt[i] + CNT_W'(1);
                        tick[i] <= 1'b0;
                    end
                    if (cfg_hit[i]) begin
                        shadow[i]  <= cfg_div;
                        pending[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the divider rules.
module tb_clk_div_bank;

    localparam int NCH  = 4;
    localparam int CW   = 8;
    localparam int DDIV = 5;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [NCH-1:0] en = '0;
    logic           sync_restart = 1'b0;
    logic           cfg_valid = 1'b0;
    logic [1:0]     cfg_ch = '0;
    logic [CW-1:0]  cfg_div = '0;
    logic           cfg_ready, cfg_err;
    logic [NCH-1:0] clk_out, tick, pending;

    logic [2:0]     en3 = '0;
    logic           sync3 = 1'b0;
    logic           cfg_valid3 = 1'b0;
    logic [1:0]     cfg_ch3 = '0;
    logic [CW-1:0]  cfg_div3 = '0;
    logic           cfg_ready3, cfg_err3;
    logic [2:0]     clk_out3, tick3, pending3;

    int n_cmp = 0;
    int n_fail = 0;

    int m_phase  [NCH];
    int m_div    [NCH];
    int m_shadow [NCH];
    int m_half   [NCH];
    bit m_pend   [NCH];
    bit m_tick   [NCH];
    bit m_err;

    clk_div_bank #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DDIV)) u_dut (
        .clk_in(clk), .rst_n(rst_n), .en(en), .sync_restart(sync_restart),
        .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err),
        .clk_out(clk_out), .tick(tick), .pending(pending)
    );

    clk_div_bank #(.NUM_CH(3), .CNT_W(CW), .DEFAULT_DIV(DDIV)) u_dut3 (
        .clk_in(clk), .rst_n(rst_n), .en(en3), .sync_restart(sync3),
        .cfg_valid(cfg_valid3), .cfg_ch(cfg_ch3), .cfg_div(cfg_div3),
        .cfg_ready(cfg_ready3), .cfg_err(cfg_err3),
        .clk_out(clk_out3), .tick(tick3), .pending(pending3)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Model: each channel tracks elapsed cycles in its half-period and how many
    // half-periods have completed; the clock level is the parity of that count.
    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_phase[i] = 0; m_div[i] = DDIV; m_shadow[i] = 0;
            m_half[i] = 0; m_pend[i] = 0; m_tick[i] = 0;
        end
        m_err = 0;
    endtask

    task automatic model_step();
        int ch;
        bit take;
        ch   = int'(cfg_ch);
        take = cfg_valid && (ch >= NCH || !m_pend[ch]);
        m_err = take && (ch >= NCH);
        for (int i = 0; i < NCH; i++) begin
            bit hit;
            hit = take && (ch == i);
            if (sync_restart) begin
                m_phase[i] = 0; m_half[i] = 0; m_tick[i] = 0;
                if (hit) m_div[i] = int'(cfg_div);
                else if (m_pend[i]) m_div[i] = m_shadow[i];
                m_pend[i] = 0;
            end else if (!en[i] || m_div[i] == 0) begin
                m_phase[i] = 0; m_half[i] = 0; m_tick[i] = 0;
                if (m_pend[i]) begin
                    m_div[i] = m_shadow[i]; m_pend[i] = 0;
                end else if (hit) begin
                    m_shadow[i] = int'(cfg_div); m_pend[i] = 1;
                end
            end else begin
                if (m_phase[i] == m_div[i] - 1) begin
                    m_phase[i] = 0; m_half[i]++; m_tick[i] = 1;
                    if (m_pend[i]) begin
                        m_div[i] = m_shadow[i]; m_pend[i] = 0;
                    end
                end else begin
                    m_phase[i]++; m_tick[i] = 0;
                end
                if (hit) begin
                    m_shadow[i] = int'(cfg_div); m_pend[i] = 1;
                end
            end
        end
    endtask

    function automatic logic [NCH-1:0] exp_clk();
        for (int i = 0; i < NCH; i++) exp_clk[i] = ((m_half[i] % 2) == 1);
    endfunction

    function automatic logic [NCH-1:0] exp_tick();
        for (int i = 0; i < NCH; i++) exp_tick[i] = m_tick[i];
    endfunction

    function automatic logic [NCH-1:0] exp_pend();
        for (int i = 0; i < NCH; i++) exp_pend[i] = m_pend[i];
    endfunction

    function automatic logic exp_ready();
        int ch;
        ch = int'(cfg_ch);
        exp_ready = (ch >= NCH) ? 1'b1 : !m_pend[ch];
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({clk_out, tick, pending, cfg_err, cfg_ready} !== {12'h000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL reset_main got clk=%b tick=%b pend=%b err=%b rdy=%b want 0/0/0/0/1",
                     clk_out, tick, pending, cfg_err, cfg_ready);
        end
        n_cmp++;
        if ({clk_out3, tick3, pending3, cfg_err3} !== 10'h000) begin
            n_fail++;
            $display("[TB] FAIL reset_dut3 got clk=%b tick=%b pend=%b err=%b want zeros",
                     clk_out3, tick3, pending3, cfg_err3);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        en3 = 3'b001;
        model_reset();
    endtask

    task automatic test_default_run();
        int ticks, toggles, last;
        bit gaps_ok, quiet;
        logic prev;
        ticks = 0; toggles = 0; last = 0; gaps_ok = 1; quiet = 1;
        en = 4'b0001;
        prev = clk_out[0];
        for (int k = 1; k <= 40; k++) begin
            step();
            if (tick[0]) begin
                ticks++;
                if (k - last != DDIV) gaps_ok = 0;
                last = k;
            end
            if (clk_out[0] !== prev) toggles++;
            prev = clk_out[0];
            if (clk_out[3:1] !== 3'b000 || tick[3:1] !== 3'b000) quiet = 0;
        end
        n_cmp++;
        if (ticks != 8) begin n_fail++; $display("[TB] FAIL default_ticks got %0d want 8", ticks); end
        n_cmp++;
        if (toggles != 8) begin n_fail++; $display("[TB] FAIL default_toggles got %0d want 8", toggles); end
        n_cmp++;
        if (!gaps_ok) begin n_fail++; $display("[TB] FAIL default_tick_gap got irregular want %0d", DDIV); end
        n_cmp++;
        if (!quiet) begin n_fail++; $display("[TB] FAIL default_idle_channels got activity want 0"); end
    endtask

    task automatic test_apply_at_terminal();
        int guard, first, second;
        bit pend_ok;
        guard = 0; first = -1; second = -1; pend_ok = 1;
        while (m_phase[0] != 1 && guard < 12) begin step(); guard++; end
        n_cmp++;
        if (m_phase[0] != 1) begin n_fail++; $display("[TB] FAIL apply_align got phase %0d want 1", m_phase[0]); end
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3;
        #1;
        n_cmp++;
        if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL apply_ready_before got %b want 1", cfg_ready); end
        step();
        cfg_valid = 1'b0;
        #1;
        n_cmp++;
        if ({pending[0], cfg_ready} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL apply_pending got pend=%b rdy=%b want 1/0", pending[0], cfg_ready);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            if (tick[0]) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            if (pending[0] !== ((k < 3) ? 1'b1 : 1'b0)) pend_ok = 0;
        end
        n_cmp++;
        if (first != 3) begin n_fail++; $display("[TB] FAIL apply_old_half got tick at %0d want 3", first); end
        n_cmp++;
        if (second != 6) begin n_fail++; $display("[TB] FAIL apply_new_half got tick at %0d want 6", second); end
        n_cmp++;
        if (!pend_ok) begin n_fail++; $display("[TB] FAIL apply_pend_clear got wrong timing want clear at 3"); end
    endtask

    task automatic test_stop_and_div1();
        int first;
        bit quiet, fast_ok;
        logic prev;
        first = -1; quiet = 1; fast_ok = 1;
        en = 4'b0101;
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd0;
        step();
        cfg_valid = 1'b0;
        n_cmp++;
        if (pending[2] !== 1'b1) begin n_fail++; $display("[TB] FAIL stop_pending got %b want 1", pending[2]); end
        for (int k = 1; k <= 4; k++) begin
            step();
            if (tick[2] && first < 0) first = k;
        end
        n_cmp++;
        if (first != 4) begin n_fail++; $display("[TB] FAIL stop_last_half got tick at %0d want 4", first); end
        for (int k = 0; k < 6; k++) begin
            step();
            if ({clk_out[2], tick[2], pending[2]} !== 3'b000) quiet = 0;
        end
        n_cmp++;
        if (!quiet) begin n_fail++; $display("[TB] FAIL stop_held got activity want clk=0 tick=0"); end
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd1;
        step();
        cfg_valid = 1'b0;
        step();
        n_cmp++;
        if ({pending[2], tick[2]} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL div1_apply got pend=%b tick=%b want 0/0", pending[2], tick[2]);
        end
        for (int k = 0; k < 6; k++) begin
            prev = clk_out[2];
            step();
            if (tick[2] !== 1'b1 || clk_out[2] === prev) fast_ok = 0;
        end
        n_cmp++;
        if (!fast_ok) begin n_fail++; $display("[TB] FAIL div1_run got irregular want tick=1 and toggle each cycle"); end
    endtask

    task automatic test_sync_restart();
        int t0, t1;
        t0 = -1; t1 = -1;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd4;
        step();
        cfg_ch = 2'd1; cfg_div = 8'd6;
        step();
        cfg_valid = 1'b0;
        en = 4'b0011;
        for (int k = 0; k < 7; k++) step();
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        n_cmp++;
        if ({clk_out[1:0], tick[1:0], pending[1:0]} !== 6'b000000) begin
            n_fail++;
            $display("[TB] FAIL sync_clear got clk=%b tick=%b pend=%b want zeros",
                     clk_out[1:0], tick[1:0], pending[1:0]);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            if (tick[0] && t0 < 0) t0 = k;
            if (tick[1] && t1 < 0) t1 = k;
        end
        n_cmp++;
        if (t0 != 4) begin n_fail++; $display("[TB] FAIL sync_ch0_first got %0d want 4", t0); end
        n_cmp++;
        if (t1 != 6) begin n_fail++; $display("[TB] FAIL sync_ch1_first got %0d want 6", t1); end
    endtask

    task automatic test_out_of_range();
        int ticks3;
        ticks3 = 0;
        cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_div3 = 8'd2;
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd2;
        #1;
        n_cmp++;
        if ({cfg_ready3, cfg_err3} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL oor_ready got rdy=%b err=%b want 1/0", cfg_ready3, cfg_err3);
        end
        step();
        cfg_valid3 = 1'b0; cfg_valid = 1'b0;
        n_cmp++;
        if ({cfg_err3, pending3} !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL oor_err_pulse got err=%b pend=%b want 1/000", cfg_err3, pending3);
        end
        n_cmp++;
        if ({pending[3], cfg_err} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL ch3_accept got pend=%b err=%b want 1/0", pending[3], cfg_err);
        end
        step();
        n_cmp++;
        if ({cfg_err3, pending3} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL oor_err_single got err=%b pend=%b want 0/000", cfg_err3, pending3);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            if (tick3[0]) ticks3++;
        end
        n_cmp++;
        if (ticks3 != 2) begin n_fail++; $display("[TB] FAIL oor_no_change got %0d ticks want 2", ticks3); end
    endtask

    task automatic test_reset_mid();
        int t1;
        t1 = -1;
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd2;
        step();
        cfg_valid = 1'b0;
        n_cmp++;
        if (pending[1] !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_setup got pend=%b want 1", pending[1]); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({clk_out, tick, pending, cfg_err} !== 13'h0000) begin
            n_fail++;
            $display("[TB] FAIL rstmid_async got clk=%b tick=%b pend=%b err=%b want zeros",
                     clk_out, tick, pending, cfg_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        en = 4'b0010;
        model_reset();
        for (int k = 1; k <= 8; k++) begin
            step();
            if (tick[1] && t1 < 0) t1 = k;
        end
        n_cmp++;
        if (t1 != DDIV) begin n_fail++; $display("[TB] FAIL rstmid_default_div got tick at %0d want %0d", t1, DDIV); end
    endtask

    task automatic test_random();
        en = 4'b1111;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 15) == 0) en = 4'($urandom);
            sync_restart = ($urandom_range(0, 31) == 0);
            cfg_valid    = ($urandom_range(0, 3) == 0);
            cfg_ch       = 2'($urandom);
            cfg_div      = 8'($urandom_range(0, 7));
            #1;
            n_cmp++;
            if (cfg_ready !== exp_ready()) begin
                n_fail++;
                $display("[TB] FAIL rand_ready cyc=%0d got %b want %b", c, cfg_ready, exp_ready());
            end
            step();
            n_cmp++;
            if ({clk_out, tick, pending, cfg_err} !== {exp_clk(), exp_tick(), exp_pend(), m_err}) begin
                n_fail++;
                $display("[TB] FAIL rand_outputs cyc=%0d got clk=%b tick=%b pend=%b err=%b want clk=%b tick=%b pend=%b err=%b",
                         c, clk_out, tick, pending, cfg_err, exp_clk(), exp_tick(), exp_pend(), m_err);
            end
        end
        sync_restart = 1'b0;
        cfg_valid = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_default_run();
        test_apply_at_terminal();
        test_stop_and_div1();
        test_sync_restart();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
